// File: rtl/bship_pkg.sv
// bship_pkg: scan codes, controller state and error codes shared by the shot-entry logic.
package bship_pkg;
  typedef enum logic [1:0] {COLLECT, CHECK, OFFER} state_t;
  typedef struct packed {
    logic       is_letter;
    logic       is_digit;
    logic [3:0] value;
  } dec_t;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_LETTER [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
  localparam logic [7:0] SC_DIGIT  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [1:0] ERR_INCOMPLETE = 2'd1;
  localparam logic [1:0] ERR_REPEAT     = 2'd2;
  function automatic dec_t sc_decode(input logic [7:0] b);
    dec_t d;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      if (b == SC_LETTER[i]) d = '{1'b1, 1'b0, 4'(i)};
      if (b == SC_DIGIT[i]) d = '{1'b0, 1'b1, 4'(i)};
    end
    return d;
  endfunction
  // row*10 + col without a multiplier
  function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return ({3'b0, y} << 3) + ({3'b0, y} << 1) + {3'b0, x};
  endfunction
endpackage

// File: rtl/fired_map.sv
// fired_map: per-player 10x10 record of cells already shot at.
module fired_map (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       rd_player,
  input  logic [6:0] rd_idx,
  output logic       rd_hit,
  input  logic       we,
  input  logic       wr_player,
  input  logic [6:0] wr_idx
);
  logic [99:0] map_q [2];
  logic [99:0] map_d [2];
  always_comb begin
    map_d = map_q;
    if (clr) map_d = '{default: '0};
    else if (we) map_d[wr_player][wr_idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) map_q <= '{default: '0};
    else map_q <= map_d;
  assign rd_hit = map_q[rd_player][rd_idx];
endmodule

// File: rtl/shot_entry_ctrl.sv
// shot_entry_ctrl: decodes PS/2 coordinate entry, rejects repeat shots and offers shots to the game core.
module shot_entry_ctrl
  import bship_pkg::*;
#(
  parameter int RX_W = 8
) (
  input  logic            CLOCK_50,
  input  logic            resetn,
  input  logic [RX_W-1:0] rx_data,
  input  logic            rx_en,
  input  logic            new_game,
  output logic            shot_valid,
  input  logic            shot_ready,
  output logic [3:0]      shot_x,
  output logic [3:0]      shot_y,
  output logic            shot_player,
  output logic [3:0]      cur_x,
  output logic [3:0]      cur_y,
  output logic            x_set,
  output logic            y_set,
  output logic            err,
  output logic [1:0]      err_code
);
  state_t     state_q, state_d;
  logic       player_q, player_d, ext_q, ext_d, brk_q, brk_d;
  logic [3:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic       x_set_q, x_set_d, y_set_q, y_set_d, err_q, err_d;
  logic       shot_valid_q, shot_valid_d, shot_player_q, shot_player_d;
  logic [1:0] err_code_q, err_code_d;
  logic       make, hit, map_we, map_clr;
  dec_t       dec;
  fired_map u_map (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .clr      (map_clr),
    .rd_player(player_q),
    .rd_idx   (cell_idx(cur_x_q, cur_y_q)),
    .rd_hit   (hit),
    .we       (map_we),
    .wr_player(shot_player_q),
    .wr_idx   (cell_idx(shot_x_q, shot_y_q))
  );
  always_comb begin
    state_d       = state_q;
    player_d      = player_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    x_set_d       = x_set_q;
    y_set_d       = y_set_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    shot_valid_d  = shot_valid_q;
    shot_x_d      = shot_x_q;
    shot_y_d      = shot_y_q;
    shot_player_d = shot_player_q;
    map_we        = 1'b0;
    map_clr       = 1'b0;
    make          = 1'b0;
    dec           = sc_decode(rx_data);
    // prefix tracking runs in every state so break sequences stay aligned
    if (rx_en && rx_data != '0) begin
      if (rx_data == SC_EXT) ext_d = 1'b1;
      else if (rx_data == SC_BREAK) brk_d = 1'b1;
      else if (ext_q || brk_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else make = 1'b1;
    end
    if (new_game) begin
      state_d      = COLLECT;
      player_d     = 1'b0;
      shot_valid_d = 1'b0;
      map_clr      = 1'b1;
    end else begin
      case (state_q)
        COLLECT: if (make) begin
          if (dec.is_letter) begin
            cur_x_d = dec.value;
            x_set_d = 1'b1;
          end else if (dec.is_digit) begin
            cur_y_d = dec.value;
            y_set_d = 1'b1;
          end else if (rx_data == SC_BKSP || rx_data == SC_ESC) begin
            cur_x_d = '0;
            cur_y_d = '0;
            x_set_d = 1'b0;
            y_set_d = 1'b0;
          end else if (rx_data == SC_ENTER) begin
            if (x_set_q && y_set_q) state_d = CHECK;
            else begin
              err_d      = 1'b1;
              err_code_d = ERR_INCOMPLETE;
            end
          end
        end
        CHECK: if (hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_REPEAT;
          state_d    = COLLECT;
        end else begin
          shot_x_d      = cur_x_q;
          shot_y_d      = cur_y_q;
          shot_player_d = player_q;
          shot_valid_d  = 1'b1;
          state_d       = OFFER;
        end
        OFFER: if (shot_ready) begin
          map_we       = 1'b1;
          player_d     = ~player_q;
          x_set_d      = 1'b0;
          y_set_d      = 1'b0;
          shot_valid_d = 1'b0;
          state_d      = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state_q       <= COLLECT;
      player_q      <= 1'b0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      x_set_q       <= 1'b0;
      y_set_q       <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      shot_valid_q  <= 1'b0;
      shot_x_q      <= '0;
      shot_y_q      <= '0;
      shot_player_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      player_q      <= player_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      x_set_q       <= x_set_d;
      y_set_q       <= y_set_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      shot_valid_q  <= shot_valid_d;
      shot_x_q      <= shot_x_d;
      shot_y_q      <= shot_y_d;
      shot_player_q <= shot_player_d;
    end
  assign shot_valid  = shot_valid_q;
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;
  assign shot_player = shot_player_q;
  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign x_set       = x_set_q;
  assign y_set       = y_set_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
endmodule

// File: tb/tb_shot_entry_ctrl.sv
// tb_shot_entry_ctrl: directed scenarios for the shot-entry controller with hand-computed expectations.
module tb_shot_entry_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic       new_game = 1'b0;
  logic       shot_ready = 1'b0;
  logic       shot_valid, shot_player, x_set, y_set, err;
  logic [3:0] shot_x, shot_y, cur_x, cur_y;
  logic [1:0] err_code;
  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int hs_cnt = 0;
  logic [3:0] hs_x = 4'd0;
  logic [3:0] hs_y = 4'd0;
  logic       hs_p = 1'b0;

  shot_entry_ctrl #(.RX_W(8)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .new_game   (new_game),
    .shot_valid (shot_valid),
    .shot_ready (shot_ready),
    .shot_x     (shot_x),
    .shot_y     (shot_y),
    .shot_player(shot_player),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .x_set      (x_set),
    .y_set      (y_set),
    .err        (err),
    .err_code   (err_code)
  );

  always #10 clk = ~clk;

  // observe handshakes and pulses mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (shot_valid) valid_cnt++;
    if (err) err_cnt++;
    if (shot_valid && shot_ready) begin
      hs_cnt++;
      hs_x = shot_x;
      hs_y = shot_y;
      hs_p = shot_player;
    end
  end

  task automatic clr_mon();
    valid_cnt = 0;
    err_cnt = 0;
    hs_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_en = 1'b1;
    @(posedge clk);
    #1 rx_en = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(3);
    checks++;
    if ({shot_valid, shot_x, shot_y, shot_player, cur_x, cur_y, x_set, y_set, err, err_code} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {shot_valid, shot_x, shot_y, shot_player, cur_x, cur_y, x_set, y_set, err, err_code});
    end
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_accept();
    do_reset();
    shot_ready = 1'b1;
    send(8'h21);
    checks++;
    if (cur_x !== 4'd2 || x_set !== 1'b1) begin
      failures++;
      $display("FAIL accept_x got=%0d/%0b exp=2/1", cur_x, x_set);
    end
    send(8'h3D);
    checks++;
    if (cur_y !== 4'd7 || y_set !== 1'b1) begin
      failures++;
      $display("FAIL accept_y got=%0d/%0b exp=7/1", cur_y, y_set);
    end
    clr_mon();
    send(8'h5A);
    checks++;
    if (shot_valid !== 1'b0) begin
      failures++;
      $display("FAIL accept_check_cycle got=%0b exp=0", shot_valid);
    end
    idle(1);
    checks++;
    if (shot_valid !== 1'b1) begin
      failures++;
      $display("FAIL accept_offer_cycle got=%0b exp=1", shot_valid);
    end
    idle(5);
    checks++;
    if (valid_cnt !== 1 || hs_cnt !== 1) begin
      failures++;
      $display("FAIL accept_valid_cycles got=%0d/%0d exp=1/1", valid_cnt, hs_cnt);
    end
    checks++;
    if ({hs_x, hs_y, hs_p} !== {4'd2, 4'd7, 1'b0}) begin
      failures++;
      $display("FAIL accept_shot got=x%0d y%0d p%0b exp=x2 y7 p0", hs_x, hs_y, hs_p);
    end
    checks++;
    if (x_set !== 1'b0 || y_set !== 1'b0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL accept_cleanup got=%0b%0b err%0d exp=00 err0", x_set, y_set, err_cnt);
    end
    clr_mon();
    send(8'h1C);
    send(8'h45);
    send(8'h5A);
    idle(5);
    checks++;
    if (hs_cnt !== 1 || hs_p !== 1'b1) begin
      failures++;
      $display("FAIL accept_toggle got=hs%0d p%0b exp=hs1 p1", hs_cnt, hs_p);
    end
  endtask

  task automatic test_filter();
    logic [7:0] seq [9];
    seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16};
    do_reset();
    clr_mon();
    foreach (seq[i]) send(seq[i]);
    checks++;
    if ({cur_x, cur_y, x_set, y_set} !== {4'd0, 4'd1, 2'b11}) begin
      failures++;
      $display("FAIL filter_seq got=x%0d y%0d %0b%0b exp=x0 y1 11", cur_x, cur_y, x_set, y_set);
    end
    send(8'h32);
    send(8'hF0);
    send(8'h1C);
    checks++;
    if (cur_x !== 4'd1) begin
      failures++;
      $display("FAIL filter_break_letter got=%0d exp=1", cur_x);
    end
    send(8'h45);
    send(8'hE0);
    send(8'h16);
    send(8'h00);
    send(8'h3E);
    checks++;
    if (cur_y !== 4'd8) begin
      failures++;
      $display("FAIL filter_ext_digit got=%0d exp=8", cur_y);
    end
    send(8'hE0);
    send(8'h5A);
    idle(4);
    checks++;
    if (valid_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL filter_ext_enter got=v%0d e%0d exp=v0 e0", valid_cnt, err_cnt);
    end
  endtask

  task automatic test_repeat();
    do_reset();
    shot_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      clr_mon();
      send(8'h1C);
      send(8'h45);
      send(8'h5A);
      idle(5);
      checks++;
      if (hs_cnt !== 1 || hs_p !== 1'(p) || hs_x !== 4'd0 || hs_y !== 4'd0) begin
        failures++;
        $display("FAIL repeat_first_p%0d got=hs%0d p%0b x%0d y%0d exp=hs1 p%0d x0 y0", p, hs_cnt, hs_p, hs_x, hs_y, p);
      end
    end
    clr_mon();
    send(8'h1C);
    send(8'h45);
    send(8'h5A);
    idle(5);
    checks++;
    if (valid_cnt !== 0 || err_cnt !== 1 || err_code !== 2'd2) begin
      failures++;
      $display("FAIL repeat_reject got=v%0d e%0d code%0d exp=v0 e1 code2", valid_cnt, err_cnt, err_code);
    end
    checks++;
    if ({x_set, y_set, cur_x, cur_y} !== {2'b11, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL repeat_kept got=%0b%0b x%0d y%0d exp=11 x0 y0", x_set, y_set, cur_x, cur_y);
    end
    clr_mon();
    send(8'h32);
    send(8'h5A);
    idle(5);
    checks++;
    if (hs_cnt !== 1 || {hs_x, hs_y, hs_p} !== {4'd1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL repeat_other_cell got=hs%0d x%0d y%0d p%0b exp=hs1 x1 y0 p0", hs_cnt, hs_x, hs_y, hs_p);
    end
  endtask

  task automatic test_incomplete();
    do_reset();
    shot_ready = 1'b1;
    clr_mon();
    send(8'h32);
    send(8'h5A);
    idle(4);
    checks++;
    if (err_cnt !== 1 || err_code !== 2'd1 || valid_cnt !== 0) begin
      failures++;
      $display("FAIL incomplete_first got=e%0d code%0d v%0d exp=e1 code1 v0", err_cnt, err_code, valid_cnt);
    end
    checks++;
    if (x_set !== 1'b1 || cur_x !== 4'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL incomplete_kept got=%0b x%0d err%0b exp=1 x1 err0", x_set, cur_x, err);
    end
    send(8'h66);
    checks++;
    if (x_set !== 1'b0 || cur_x !== 4'd0) begin
      failures++;
      $display("FAIL incomplete_bksp got=%0b x%0d exp=0 x0", x_set, cur_x);
    end
    clr_mon();
    send(8'h5A);
    idle(4);
    checks++;
    if (err_cnt !== 1 || err_code !== 2'd1 || valid_cnt !== 0) begin
      failures++;
      $display("FAIL incomplete_second got=e%0d code%0d v%0d exp=e1 code1 v0", err_cnt, err_code, valid_cnt);
    end
    send(8'h2E);
    send(8'h76);
    checks++;
    if (y_set !== 1'b0 || cur_y !== 4'd0) begin
      failures++;
      $display("FAIL incomplete_esc got=%0b y%0d exp=0 y0", y_set, cur_y);
    end
  endtask

  task automatic test_backpressure();
    int unstable;
    do_reset();
    shot_ready = 1'b0;
    clr_mon();
    send(8'h2B);
    send(8'h26);
    send(8'h5A);
    idle(2);
    checks++;
    if ({shot_valid, shot_x, shot_y, shot_player} !== {1'b1, 4'd5, 4'd3, 1'b0}) begin
      failures++;
      $display("FAIL bp_offer got=v%0b x%0d y%0d p%0b exp=v1 x5 y3 p0", shot_valid, shot_x, shot_y, shot_player);
    end
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if ({shot_valid, shot_x, shot_y, shot_player} !== {1'b1, 4'd5, 4'd3, 1'b0}) unstable++;
    end
    checks++;
    if (unstable !== 0) begin
      failures++;
      $display("FAIL bp_stable got=%0d unstable cycles exp=0", unstable);
    end
    send(8'h24);
    checks++;
    if (cur_x !== 4'd5 || shot_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_drop_make got=x%0d v%0b exp=x5 v1", cur_x, shot_valid);
    end
    shot_ready = 1'b1;
    idle(3);
    checks++;
    if (hs_cnt !== 1 || shot_valid !== 1'b0 || hs_x !== 4'd5) begin
      failures++;
      $display("FAIL bp_release got=hs%0d v%0b x%0d exp=hs1 v0 x5", hs_cnt, shot_valid, hs_x);
    end
    shot_ready = 1'b0;
    send(8'h1C);
    send(8'h45);
    send(8'h5A);
    idle(2);
    checks++;
    if (shot_valid !== 1'b1 || shot_player !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_offer got=v%0b p%0b exp=v1 p1", shot_valid, shot_player);
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({shot_valid, shot_x, shot_y, shot_player, cur_x, cur_y, x_set, y_set, err, err_code} !== 23'd0) begin
      failures++;
      $display("FAIL bp_async_reset got=%h exp=0", {shot_valid, shot_x, shot_y, shot_player, cur_x, cur_y, x_set, y_set, err, err_code});
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    shot_ready = 1'b1;
    clr_mon();
    send(8'h2B);
    send(8'h26);
    send(8'h5A);
    idle(5);
    checks++;
    if (hs_cnt !== 1 || hs_p !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_reset got=hs%0d p%0b exp=hs1 p0", hs_cnt, hs_p);
    end
  endtask

  task automatic test_new_game();
    do_reset();
    shot_ready = 1'b1;
    clr_mon();
    send(8'h3B);
    send(8'h46);
    send(8'h5A);
    idle(5);
    checks++;
    if (hs_cnt !== 1 || {hs_x, hs_y, hs_p} !== {4'd9, 4'd9, 1'b0}) begin
      failures++;
      $display("FAIL ng_first got=hs%0d x%0d y%0d p%0b exp=hs1 x9 y9 p0", hs_cnt, hs_x, hs_y, hs_p);
    end
    @(posedge clk);
    #1 new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    clr_mon();
    send(8'h3B);
    send(8'h46);
    send(8'h5A);
    idle(5);
    checks++;
    if (hs_cnt !== 1 || err_cnt !== 0 || hs_p !== 1'b0) begin
      failures++;
      $display("FAIL ng_refire got=hs%0d e%0d p%0b exp=hs1 e0 p0", hs_cnt, err_cnt, hs_p);
    end
    shot_ready = 1'b0;
    clr_mon();
    send(8'h43);
    send(8'h3E);
    send(8'h5A);
    idle(2);
    @(posedge clk);
    #1 new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    shot_ready = 1'b1;
    checks++;
    if (shot_valid !== 1'b0 || hs_cnt !== 0) begin
      failures++;
      $display("FAIL ng_in_offer got=v%0b hs%0d exp=v0 hs0", shot_valid, hs_cnt);
    end
    send(8'h43);
    send(8'h3E);
    send(8'h5A);
    idle(5);
    checks++;
    if (hs_cnt !== 1 || err_cnt !== 0 || {hs_x, hs_y, hs_p} !== {4'd8, 4'd8, 1'b0}) begin
      failures++;
      $display("FAIL ng_not_marked got=hs%0d e%0d x%0d y%0d p%0b exp=hs1 e0 x8 y8 p0", hs_cnt, err_cnt, hs_x, hs_y, hs_p);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_filter();
    test_repeat();
    test_incomplete();
    test_backpressure();
    test_new_game();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
